// File: rtl/sp_request_arbiter.sv
// Round-robin merge of MLS and GEMM requests into 38-bit scratchpad FIFO entries; one-slot capture, push no earlier than the cycle after accept.
// Backpressure: fifo_full, the credit limit or a halted state holds the slots; ready drops while a slot is held or once the drain has begun.
module sp_request_arbiter #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             mls_req,
  input  logic [1:0]       mls_ls,
  input  logic [3:0]       mls_rd,
  input  logic [31:0]      mls_addr,
  output logic             mls_ready,
  input  logic             gemm_req,
  input  logic             gemm_new_weight,
  input  logic [15:0]      gemm_sel,
  output logic             gemm_ready,
  input  logic             fifo_full,
  output logic             fifo_wen,
  output logic [37:0]      fifo_wdata,
  input  logic             load_complete,
  input  logic             store_complete,
  input  logic             gemm_complete,
  input  logic             halt,
  output logic             halt_done,
  output logic [CNT_W-1:0] outstanding,
  output logic             err
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [3:0]  tag;
    logic [31:0] addr;
  } sp_entry_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  state_t           state_q, state_d;
  logic             mls_vld_q, mls_vld_d;
  sp_entry_t        mls_dat_q, mls_dat_d;
  logic             gemm_vld_q, gemm_vld_d;
  sp_entry_t        gemm_dat_q, gemm_dat_d;
  logic             last_gemm_q, last_gemm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             can_push, push, grant_mls, push_mls, push_gemm;
  logic             mls_acc, mls_legal, gemm_acc, underflow;
  logic [1:0]       dec;
  logic [CNT_W:0]   sum;

  always_comb begin
    can_push   = !fifo_full && (cnt_q < MAX_CNT) && (state_q != ST_HALTED);
    // MLS wins when alone, or when both are waiting and GEMM took the last push.
    grant_mls  = mls_vld_q && (!gemm_vld_q || last_gemm_q);
    push       = can_push && (mls_vld_q || gemm_vld_q);
    push_mls   = push && grant_mls;
    push_gemm  = push && !grant_mls;

    mls_ready  = (state_q == ST_RUN) && (!mls_vld_q || push_mls);
    gemm_ready = (state_q == ST_RUN) && (!gemm_vld_q || push_gemm);
    fifo_wen   = push;
    fifo_wdata = grant_mls ? mls_dat_q : gemm_dat_q;

    mls_acc    = mls_req && mls_ready;
    mls_legal  = (mls_ls == 2'b01) || (mls_ls == 2'b10);
    gemm_acc   = gemm_req && gemm_ready;

    mls_vld_d  = mls_vld_q && !push_mls;
    mls_dat_d  = mls_dat_q;
    if (mls_acc) begin
      // Illegal op codes are consumed from the requester but never stored.
      mls_vld_d = mls_legal;
      if (mls_legal) begin
        mls_dat_d.op   = mls_ls;
        mls_dat_d.tag  = mls_rd;
        mls_dat_d.addr = mls_addr;
      end
    end

    gemm_vld_d = gemm_vld_q && !push_gemm;
    gemm_dat_d = gemm_dat_q;
    if (gemm_acc) begin
      gemm_vld_d      = 1'b1;
      gemm_dat_d.op   = 2'b11;
      gemm_dat_d.tag  = {gemm_new_weight, 3'b000};
      gemm_dat_d.addr = {16'd0, gemm_sel};
    end

    last_gemm_d = push ? !grant_mls : last_gemm_q;

    dec       = 2'(load_complete) + 2'(store_complete) + 2'(gemm_complete);
    sum       = {1'b0, cnt_q} + (CNT_W + 1)'(push);
    underflow = sum < (CNT_W + 1)'(dec);
    cnt_d     = underflow ? '0 : CNT_W'(sum - (CNT_W + 1)'(dec));

    err_d = err_q || underflow || (mls_acc && !mls_legal);

    state_d = state_q;
    case (state_q)
      ST_RUN:    if (halt) state_d = ST_DRAIN;
      ST_DRAIN:  if (!mls_vld_q && !gemm_vld_q && (cnt_q == '0) && (cnt_d == '0))
                   state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= ST_RUN;
      mls_vld_q   <= 1'b0;
      mls_dat_q   <= '0;
      gemm_vld_q  <= 1'b0;
      gemm_dat_q  <= '0;
      last_gemm_q <= 1'b1;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mls_vld_q   <= mls_vld_d;
      mls_dat_q   <= mls_dat_d;
      gemm_vld_q  <= gemm_vld_d;
      gemm_dat_q  <= gemm_dat_d;
      last_gemm_q <= last_gemm_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign halt_done   = (state_q == ST_HALTED);
  assign outstanding = cnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_sp_request_arbiter.sv
// Directed bench for sp_request_arbiter: inputs change on the falling edge, outputs are checked 1 time unit later.
module tb_sp_request_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        mls_req;
  logic [1:0]  mls_ls;
  logic [3:0]  mls_rd;
  logic [31:0] mls_addr;
  logic        mls_ready;
  logic        gemm_req;
  logic        gemm_new_weight;
  logic [15:0] gemm_sel;
  logic        gemm_ready;
  logic        fifo_full;
  logic        fifo_wen;
  logic [37:0] fifo_wdata;
  logic        load_complete;
  logic        store_complete;
  logic        gemm_complete;
  logic        halt;
  logic        halt_done;
  logic [3:0]  outstanding;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  sp_request_arbiter #(.MAX_OUTSTANDING(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .mls_req(mls_req), .mls_ls(mls_ls), .mls_rd(mls_rd), .mls_addr(mls_addr), .mls_ready(mls_ready),
    .gemm_req(gemm_req), .gemm_new_weight(gemm_new_weight), .gemm_sel(gemm_sel), .gemm_ready(gemm_ready),
    .fifo_full(fifo_full), .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata),
    .load_complete(load_complete), .store_complete(store_complete), .gemm_complete(gemm_complete),
    .halt(halt), .halt_done(halt_done), .outstanding(outstanding), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    nRST = 1'b0; mls_req = 1'b0; mls_ls = 2'b00; mls_rd = 4'd0; mls_addr = 32'd0;
    gemm_req = 1'b0; gemm_new_weight = 1'b0; gemm_sel = 16'd0; fifo_full = 1'b0;
    load_complete = 1'b0; store_complete = 1'b0; gemm_complete = 1'b0; halt = 1'b0;
    tick(); tick();
    nRST = 1'b1;
    #1;
    chk("rst_mls_ready", mls_ready, 1);
    chk("rst_gemm_ready", gemm_ready, 1);
    chk("rst_wen", fifo_wen, 0);
    chk("rst_halt_done", halt_done, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err, 0);

    // Single load: captured this cycle, pushed next cycle.
    mls_req = 1'b1; mls_ls = 2'b01; mls_rd = 4'd3; mls_addr = 32'h1000;
    #1 chk("t1_wen_accept_cycle", fifo_wen, 0);
    tick();
    mls_req = 1'b0;
    #1;
    chk("t1_wen", fifo_wen, 1);
    chk("t1_wdata", fifo_wdata, {2'b01, 4'd3, 32'h1000});
    chk("t1_ready_on_push", mls_ready, 1);
    tick();
    #1 chk("t1_outstanding", outstanding, 1);
    load_complete = 1'b1;
    tick();
    load_complete = 1'b0;
    #1 chk("t1_retired", outstanding, 0);

    // Reset mid-stream restores last_grant=GEMM; both slots loaded together.
    nRST = 1'b0; tick(); nRST = 1'b1;
    mls_req = 1'b1; mls_ls = 2'b10; mls_rd = 4'd7; mls_addr = 32'h2000;
    gemm_req = 1'b1; gemm_new_weight = 1'b1; gemm_sel = 16'h0005;
    tick();
    mls_req = 1'b0; gemm_req = 1'b0;
    #1;
    chk("t2_wen0", fifo_wen, 1);
    chk("t2_mls_first", fifo_wdata, {2'b10, 4'd7, 32'h2000});
    chk("t2_gemm_held", gemm_ready, 0);
    tick();
    #1;
    chk("t2_wen1", fifo_wen, 1);
    chk("t2_gemm_second", fifo_wdata, {2'b11, 4'b1000, 16'd0, 16'h0005});
    tick();
    #1;
    chk("t2_idle", fifo_wen, 0);
    chk("t2_outstanding", outstanding, 2);
    store_complete = 1'b1; gemm_complete = 1'b1;
    tick();
    store_complete = 1'b0; gemm_complete = 1'b0;
    #1 chk("t2_retired", outstanding, 0);

    // FIFO full for 4 cycles with both slots held.
    fifo_full = 1'b1;
    mls_req = 1'b1; mls_ls = 2'b01; mls_rd = 4'd1; mls_addr = 32'h0000_0030;
    gemm_req = 1'b1; gemm_new_weight = 1'b0; gemm_sel = 16'h000A;
    tick();
    mls_req = 1'b0; gemm_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_full_wen", fifo_wen, 0);
      chk("t3_full_mls_ready", mls_ready, 0);
      chk("t3_full_gemm_ready", gemm_ready, 0);
      chk("t3_full_data", fifo_wdata, {2'b01, 4'd1, 32'h0000_0030});
      tick();
    end
    fifo_full = 1'b0;
    #1;
    chk("t3_resume_wen", fifo_wen, 1);
    chk("t3_resume_data", fifo_wdata, {2'b01, 4'd1, 32'h0000_0030});
    tick();
    #1;
    chk("t3_gemm_wen", fifo_wen, 1);
    chk("t3_gemm_data", fifo_wdata, {2'b11, 4'b0000, 16'd0, 16'h000A});
    tick();
    #1 chk("t3_outstanding", outstanding, 2);
    load_complete = 1'b1; gemm_complete = 1'b1;
    tick();
    load_complete = 1'b0; gemm_complete = 1'b0;
    #1 chk("t3_retired", outstanding, 0);

    // Nine back-to-back loads against a credit limit of 8.
    mls_req = 1'b1; mls_ls = 2'b01; mls_rd = 4'd2;
    for (int i = 0; i < 9; i++) begin
      mls_addr = 32'h100 + 32'(i);
      #1 chk("t4_ready", mls_ready, 1);
      tick();
    end
    mls_req = 1'b0;
    #1;
    chk("t4_limit_count", outstanding, 8);
    chk("t4_limit_wen", fifo_wen, 0);
    chk("t4_limit_ready", mls_ready, 0);
    chk("t4_ninth_held", fifo_wdata, {2'b01, 4'd2, 32'h108});
    gemm_complete = 1'b1;
    tick();
    gemm_complete = 1'b0;
    #1;
    chk("t4_ninth_wen", fifo_wen, 1);
    chk("t4_ninth_data", fifo_wdata, {2'b01, 4'd2, 32'h108});
    chk("t4_count_dip", outstanding, 7);
    tick();
    #1 chk("t4_count_back", outstanding, 8);

    // Underflow: two retirements against one in flight.
    load_complete = 1'b1;
    repeat (7) tick();
    load_complete = 1'b0;
    #1;
    chk("t5_count1", outstanding, 1);
    chk("t5_err_clear", err, 0);
    load_complete = 1'b1; store_complete = 1'b1;
    tick();
    load_complete = 1'b0; store_complete = 1'b0;
    #1;
    chk("t5_saturate", outstanding, 0);
    chk("t5_err_set", err, 1);

    // Halt with two ops in flight.
    nRST = 1'b0; tick(); nRST = 1'b1;
    #1 chk("t6_err_cleared", err, 0);
    mls_req = 1'b1; mls_ls = 2'b01; mls_rd = 4'd4; mls_addr = 32'h40;
    tick();
    mls_ls = 2'b10; mls_rd = 4'd5; mls_addr = 32'h50;
    #1 chk("t6_b2b_ready", mls_ready, 1);
    tick();
    mls_req = 1'b0;
    #1;
    chk("t6_second_wen", fifo_wen, 1);
    chk("t6_second_data", fifo_wdata, {2'b10, 4'd5, 32'h50});
    tick();
    #1 chk("t6_in_flight", outstanding, 2);
    halt = 1'b1;
    tick();
    halt = 1'b0; mls_req = 1'b1;
    #1;
    chk("t6_drain_mls_ready", mls_ready, 0);
    chk("t6_drain_gemm_ready", gemm_ready, 0);
    chk("t6_drain_not_done", halt_done, 0);
    tick();
    mls_req = 1'b0;
    #1 chk("t6_drain_no_accept", fifo_wen, 0);
    load_complete = 1'b1; store_complete = 1'b1;
    tick();
    load_complete = 1'b0; store_complete = 1'b0;
    #1 chk("t6_drained_count", outstanding, 0);
    tick();
    gemm_req = 1'b1;
    #1;
    chk("t6_halt_done", halt_done, 1);
    chk("t6_halted_ready", gemm_ready, 0);
    chk("t6_halted_err", err, 0);
    tick();
    gemm_req = 1'b0;
    #1 chk("t6_halted_wen", fifo_wen, 0);
    nRST = 1'b0; tick(); nRST = 1'b1;
    #1;
    chk("t6_reset_halt_done", halt_done, 0);
    chk("t6_reset_ready", mls_ready, 1);
    chk("t6_reset_count", outstanding, 0);

    // Illegal mls_ls is accepted, dropped and flagged.
    mls_req = 1'b1; mls_ls = 2'b11; mls_rd = 4'd9; mls_addr = 32'hDEAD;
    #1 chk("t7_illegal_ready", mls_ready, 1);
    tick();
    mls_req = 1'b0;
    #1;
    chk("t7_illegal_dropped", fifo_wen, 0);
    chk("t7_illegal_err", err, 1);
    chk("t7_slot_free", mls_ready, 1);

    // Halt while idle: one DRAIN cycle then HALTED.
    nRST = 1'b0; tick(); nRST = 1'b1;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    #1;
    chk("t8_idle_drain", halt_done, 0);
    chk("t8_idle_ready", mls_ready, 0);
    tick();
    #1 chk("t8_idle_halted", halt_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
